data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the single data SRAM between two requesters:
//   - port 0: the CPU bus interface (LD/ST, stack push/pop for RCALL/RET).
//   - port 1: a secondary master (DMA / debug loader).
//  Each port uses a req/ack handshake. Port 0 has priority. A starvation
//  counter guarantees port 1 a slot. Addresses outside the SRAM window
//  complete without touching the memory.
// PARAMETERS
//  DATA_WIDTH      8      data bus width
//  ADDR_WIDTH      16     address width, both ports
//  MEM_START_ADDR  16'h40 first SRAM address (inclusive)
//  MEM_STOP_ADDR   16'hBF last SRAM address (inclusive)
//  MAX_CPU_BURST   4      consecutive port-0 grants allowed while port 1 waits
// PORTS
//  clk        in   1           clock
//  reset      in   1           synchronous, active-high
//  p0_req     in   1           port 0 access request (held until p0_ack)
//  p0_we      in   1           port 0: 1 = write, 0 = read
//  p0_addr    in   ADDR_WIDTH  port 0 address
//  p0_wdata   in   DATA_WIDTH  port 0 write data
//  p0_ack     out  1           port 0 one-cycle completion pulse
//  p0_rdata   out  DATA_WIDTH  port 0 read data, valid while p0_ack=1
//  p1_*       same set as p0_*, for port 1
//  mem_cs     out  1           SRAM chip select
//  mem_we     out  1           SRAM write enable
//  mem_oe     out  1           SRAM output enable
//  mem_addr   out  ADDR_WIDTH  SRAM address, offset removed: addr-MEM_START_ADDR
//  mem_wdata  out  DATA_WIDTH  SRAM write data
//  mem_rdata  in   DATA_WIDTH  SRAM read data, valid on the cycle after cs&oe
//  err        out  1           one-cycle pulse with ack for an out-of-window access
// BEHAVIOUR
//  Reset values:
//   - All outputs 0. state=IDLE, owner=0, starve_cnt=0.
//   - Reset mid-access aborts it: no ack is issued, and the requester re-issues.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Fixed 3 cycles per access; the edge
//   leaving RESP always returns to IDLE.
//  IDLE:
//   - Any req high: choose the winner and latch its we/addr/wdata and the
//     owner, then go to ACCESS. Otherwise stay in IDLE.
//  ACCESS (one cycle):
//   - In-window: mem_cs=1, mem_we=we, mem_oe=~we, mem_addr and mem_wdata
//     from the latched values.
//   - Out-of-window: all mem_* stay 0.
//   - Always go to RESP.
//  RESP (one cycle):
//   - pN_ack=1 for the owner only.
//   - Read: pN_rdata = mem_rdata, or 0 if out-of-window. Write: pN_rdata = 0.
//   - err=1 if the access was out-of-window.
//  Outside RESP, acks, err and rdata are 0.
//  Arbitration (IDLE only):
//   - Only one port requesting: that port wins.
//   - Both requesting: port 1 wins if starve_cnt == MAX_CPU_BURST, else port 0.
//  starve_cnt:
//   - Increments (saturating at MAX_CPU_BURST) on a port-0 grant while p1_req=1.
//   - Clears on a port-1 grant.
//   - Clears in IDLE when p1_req=0.
//  Handshake:
//   - Requesters hold req, we, addr and wdata stable from req rise until ack.
//   - A requester drops req on the edge that samples ack. req high in IDLE
//     is always a new request.
//  Signals that change while in ACCESS or RESP are ignored: the latched copies
//   are used.
//  The window check uses unsigned compares on the full ADDR_WIDTH. The
//   mem_addr subtraction wraps modulo 2^ADDR_WIDTH.
// TESTING
//  1. p0 write 0x5A @0x0041: mem_cs=1, mem_we=1, mem_addr=0x0001 in ACCESS;
//     p0_ack two cycles after the grant edge; err=0.
//  2. p0 read @0x0041 (SRAM returns 0x5A): p0_rdata=0x5A with p0_ack;
//     mem_oe=1 only in ACCESS.
//  3. p0 and p1 requesting continuously: grant order is 0,0,0,0,1,0,0,0,0,1...
//     starve_cnt returns to 0 after each port-1 grant.
//  4. p1 read @0x00C0 (out-of-window): no mem_cs; p1_ack=1, err=1, p1_rdata=0.
//  5. Reset asserted in ACCESS: next cycle state=IDLE and all outputs 0; no ack.
//     After release, a held p0_req is serviced normally.
//  6. Both req rise in the same cycle, starve_cnt=0: port 0 served first;
//     port 1 served on the following IDLE; no ack overlap.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares one data SRAM between two req/ack masters. Port 0 (CPU bus) has
//   priority. A saturating starvation counter lets port 1 win a tie after
//   MAX_CPU_BURST consecutive port-0 grants. Every access takes three cycles:
//   IDLE (arbitrate and latch) -> ACCESS (drive SRAM) -> RESP (ack).
//   An access to an address outside [MEM_START_ADDR, MEM_STOP_ADDR] completes
//   with err and does not touch the SRAM.
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   pN_req/we/addr/wdata         request, held stable until pN_ack
//   pN_ack, pN_rdata             one-cycle completion pulse, read data with it
//   mem_cs/we/oe/addr/wdata      SRAM controls, asserted only in ACCESS
//   mem_rdata                    SRAM read data, valid the cycle after cs&oe
//   err                          out-of-window flag, pulses with ack
module data_bus_arbiter #(
  parameter int unsigned            DATA_WIDTH     = 8,
  parameter int unsigned            ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0]  MEM_START_ADDR = 'h40,
  parameter logic [ADDR_WIDTH-1:0]  MEM_STOP_ADDR  = 'hBF,
  parameter int unsigned            MAX_CPU_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  err
);

  localparam int unsigned CNT_W = (MAX_CPU_BURST > 0) ? $clog2(MAX_CPU_BURST + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CPU_BURST);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  in_win_q, in_win_d;
  logic [CNT_W-1:0]      starve_q, starve_d;

  logic                  grant_p1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] resp_rdata;

  // Next-state, arbitration and request latching
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    in_win_d = in_win_q;
    starve_d = starve_q;
    grant_p1 = 1'b0;
    sel_addr = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A lone requester always wins; on a tie port 1 wins only once the
        // counter has saturated.
        grant_p1 = p1_req && (!p0_req || (starve_q == CNT_MAX));
        sel_addr = grant_p1 ? p1_addr : p0_addr;

        if (!p1_req || grant_p1) begin
          starve_d = '0;
        end else if (starve_q != CNT_MAX) begin
          // p1 waiting and not granted: port 0 took this slot
          starve_d = starve_q + 1'b1;
        end

        if (p0_req || p1_req) begin
          owner_d  = grant_p1;
          we_d     = grant_p1 ? p1_we    : p0_we;
          addr_d   = sel_addr;
          wdata_d  = grant_p1 ? p1_wdata : p0_wdata;
          in_win_d = (sel_addr >= MEM_START_ADDR) && (sel_addr <= MEM_STOP_ADDR);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so reset clears them all
  always_comb begin
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    p0_ack     = 1'b0;
    p1_ack     = 1'b0;
    p0_rdata   = '0;
    p1_rdata   = '0;
    err        = 1'b0;
    resp_rdata = '0;

    if (state_q == ST_ACCESS && in_win_q) begin
      mem_cs    = 1'b1;
      mem_we    = we_q;
      mem_oe    = !we_q;
      mem_addr  = addr_q - MEM_START_ADDR;
      mem_wdata = wdata_q;
    end

    if (state_q == ST_RESP) begin
      err = !in_win_q;
      if (!we_q && in_win_q) begin
        resp_rdata = mem_rdata;
      end
      if (owner_q) begin
        p1_ack   = 1'b1;
        p1_rdata = resp_rdata;
      end else begin
        p0_ack   = 1'b1;
        p0_rdata = resp_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      in_win_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      in_win_q <= in_win_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter
//   Randomised bench for data_bus_arbiter. Two requesters issue transactions
//   against an SRAM model; a transaction-level reference (busy phase,
//   starvation count, expected memory image) predicts every output each cycle.
module tb_data_bus_arbiter;

  localparam logic [15:0] START = 16'h0040;
  localparam logic [15:0] STOP  = 16'h00BF;
  localparam int          BURST = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p1_addr;
  logic [7:0]  p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [7:0]  p0_rdata, p1_rdata;
  logic        mem_cs, mem_we, mem_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (16),
    .MEM_START_ADDR(START),
    .MEM_STOP_ADDR (STOP),
    .MAX_CPU_BURST (BURST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .p0_req   (p0_req),
    .p0_we    (p0_we),
    .p0_addr  (p0_addr),
    .p0_wdata (p0_wdata),
    .p0_ack   (p0_ack),
    .p0_rdata (p0_rdata),
    .p1_req   (p1_req),
    .p1_we    (p1_we),
    .p1_addr  (p1_addr),
    .p1_wdata (p1_wdata),
    .p1_ack   (p1_ack),
    .p1_rdata (p1_rdata),
    .mem_cs   (mem_cs),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .err      (err)
  );

  // SRAM behaviour as seen by the DUT
  logic [7:0] sram   [0:65535];
  // Reference image of what the SRAM should hold, keyed by window offset
  logic [7:0] expmem [0:65535];

  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_rdata <= sram[mem_addr];
    if (mem_cs && mem_we) sram[mem_addr] <= mem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 25)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    case ($urandom % 9)
      0: return 16'h003F;
      1: return 16'h0040;
      2: return 16'h0041;
      3: return 16'h00BF;
      4: return 16'h00C0;
      5: return ($urandom % 2) ? 16'h0000 : 16'hFFFF;
      6: return 16'($urandom);
      default: return 16'h0040 + 16'($urandom % 128);
    endcase
  endfunction

  task automatic new_req(input int p);
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
    w = 1'($urandom % 2);
    a = pick_addr();
    d = 8'($urandom);
    if (p == 0) begin
      p0_req = 1'b1; p0_we = w; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = 1'b1; p1_we = w; p1_addr = a; p1_wdata = d;
    end
  endtask

  // Reference state
  int          phase;      // 0 idle, 1 memory cycle, 2 response cycle
  int          starve;
  int          owner;
  logic        t_we, t_in;
  logic [15:0] t_addr;
  logic [7:0]  t_wdata;

  initial begin
    logic        e_cs, e_we, e_oe, e_err;
    logic [15:0] e_maddr;
    logic [7:0]  e_mwd, e_rd;
    logic        e_ack [2];
    int          prob;
    bit          allow_rst;
    logic        r0, r1;
    int          win;

    for (int unsigned i = 0; i < 65536; i++) begin
      sram[i]   = 8'(i * 7 + 3);
      expmem[i] = 8'(i * 7 + 3);
    end

    reset = 1'b1;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    phase = 0; starve = 0; owner = 0;
    t_we = 0; t_in = 0; t_addr = '0; t_wdata = '0;

    @(negedge clk);
    @(negedge clk);
    // Held requests before release must not disturb reset state
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0041; p0_wdata = 8'h5A;
    @(negedge clk);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Expected outputs for the cycle currently on the bus
      e_cs = 0; e_we = 0; e_oe = 0; e_maddr = '0; e_mwd = '0;
      e_err = 0; e_rd = '0; e_ack[0] = 0; e_ack[1] = 0;
      if (phase == 1 && t_in) begin
        e_cs = 1; e_we = t_we; e_oe = !t_we;
        e_maddr = t_addr - START; e_mwd = t_wdata;
      end
      if (phase == 2) begin
        e_ack[owner] = 1;
        e_err = !t_in;
        if (!t_we && t_in) e_rd = expmem[t_addr - START];
      end

      check_eq("mem_cs",    32'(mem_cs),    32'(e_cs));
      check_eq("mem_we",    32'(mem_we),    32'(e_we));
      check_eq("mem_oe",    32'(mem_oe),    32'(e_oe));
      check_eq("mem_addr",  32'(mem_addr),  32'(e_maddr));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(e_mwd));
      check_eq("p0_ack",    32'(p0_ack),    32'(e_ack[0]));
      check_eq("p1_ack",    32'(p1_ack),    32'(e_ack[1]));
      check_eq("p0_rdata",  32'(p0_rdata),  32'(e_ack[0] ? e_rd : 8'h00));
      check_eq("p1_rdata",  32'(p1_rdata),  32'(e_ack[1] ? e_rd : 8'h00));
      check_eq("err",       32'(err),       32'(e_err));

      // Traffic mix: sparse, then saturated (both always requesting), then mixed
      if (cyc < 900)       begin prob = 30;  allow_rst = 1; end
      else if (cyc < 1800) begin prob = 100; allow_rst = 0; end
      else                 begin prob = 60;  allow_rst = 1; end

      reset = 1'b0;
      if (e_ack[0])                               p0_req = 1'b0;
      else if (!p0_req && ($urandom % 100) < prob) new_req(0);
      if (e_ack[1])                               p1_req = 1'b0;
      else if (!p1_req && ($urandom % 100) < prob) new_req(1);
      if (allow_rst && ($urandom % 120) == 0) reset = 1'b1;

      // Advance the reference across the coming clock edge
      if (phase == 1 && t_in && t_we) expmem[t_addr - START] = t_wdata;
      if (reset) begin
        phase = 0; starve = 0;
      end else if (phase == 0) begin
        r0 = p0_req; r1 = p1_req;
        win = -1;
        if (r0 && r1)  win = (starve == BURST) ? 1 : 0;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        if (!r1 || win == 1) starve = 0;
        else if (win == 0)   starve = (starve + 1 > BURST) ? BURST : starve + 1;
        if (win >= 0) begin
          owner   = win;
          t_we    = (win == 1) ? p1_we    : p0_we;
          t_addr  = (win == 1) ? p1_addr  : p0_addr;
          t_wdata = (win == 1) ? p1_wdata : p0_wdata;
          t_in    = (t_addr >= START) && (t_addr <= STOP);
          phase   = 1;
        end
      end else begin
        phase = (phase == 1) ? 2 : 0;
      end

      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
